// File: rtl/load_store_unit.sv
// Load/store requester for a byte-lane memory with a 2-cycle registered read.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests answered with resp_misaligned).
module load_store_unit #(
    parameter int MEM_BITS = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        resp_misaligned,
`endif
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_write_to,
    output logic [31:0] mem_write_value,
    input  logic [31:0] mem_read_value
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] WAIT2 = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [31:0] ADDR_MASK = (MEM_BITS >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << MEM_BITS) - 32'd1);

    logic [2:0]  state_q, state_d;
    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_write_to_q;
    logic [31:0] mem_write_value_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;

    logic        accept;
    logic        trap_take;
    logic [31:0] aligned_addr;
    logic [3:0]  lane_en;
    logic [31:0] lane_val;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic resp_misaligned_q;
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign trap_take  = misaligned;
    assign resp_misaligned = resp_misaligned_q;

    // Pulses alongside resp_valid only for a trapped request.
    always_ff @(posedge clock) begin
        if (!reset_n) resp_misaligned_q <= 1'b0;
        else          resp_misaligned_q <= accept && misaligned;
    end
`else
    assign trap_take = 1'b0;
`endif

    // Without the trap, misaligned low address bits are simply dropped.
    always_comb begin
        aligned_addr = req_addr;
        lane_en      = 4'b1111;
        lane_val     = req_wdata;
        case (req_size)
            2'b00: begin
                lane_en  = 4'b0001 << req_addr[1:0];
                lane_val = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned_addr = {req_addr[31:1], 1'b0};
                lane_en      = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_val     = {2{req_wdata[15:0]}};
            end
            default: aligned_addr = {req_addr[31:2], 2'b00};
        endcase
    end

    always_comb begin
        shifted   = mem_read_value >> {off_q, 3'b000};
        load_data = shifted;
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = unsigned_q ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = trap_take ? RESP : ISSUE;
            ISSUE:   state_d = store_q ? RESP : WAIT1;
            WAIT1:   state_d = WAIT2;
            WAIT2:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            store_q           <= 1'b0;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            off_q             <= 2'b00;
            rd_q              <= 5'd0;
            mem_write_q       <= 1'b0;
            mem_addr_q        <= 32'd0;
            mem_write_to_q    <= 4'd0;
            mem_write_value_q <= 32'd0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= 32'd0;
            resp_rd_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            if (accept) begin
                store_q    <= req_store;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                off_q      <= aligned_addr[1:0];
                rd_q       <= req_rd;
                if (trap_take) begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= 32'd0;
                    resp_rd_q    <= req_rd;
                end else begin
                    mem_write_q       <= req_store;
                    mem_addr_q        <= aligned_addr & ADDR_MASK;
                    mem_write_to_q    <= req_store ? lane_en : 4'b0000;
                    mem_write_value_q <= lane_val;
                end
            end
            if (state_q == ISSUE && store_q) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= 32'd0;
                resp_rd_q    <= rd_q;
            end
            // Read data from the ISSUE address lands during WAIT2.
            if (state_q == WAIT2) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= load_data;
                resp_rd_q    <= rd_q;
            end
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_write       = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_write_to    = mem_write_to_q;
    assign mem_write_value = mem_write_value_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_rd         = resp_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-lane memory model (2-cycle registered read).
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        resp_misaligned;
`endif
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_write_to;
    logic [31:0] mem_write_value;
    logic [31:0] mem_read_value;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_BITS(12)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
`ifdef LSU_MISALIGN_TRAP_EN
        .resp_misaligned (resp_misaligned),
`endif
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_write_to    (mem_write_to),
        .mem_write_value (mem_write_value),
        .mem_read_value  (mem_read_value)
    );

    // Memory model: byte-enable writes, read data two edges after the address.
    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic [31:0] rd1 = 32'd0;
    logic [31:0] rd2 = 32'd0;
    logic [11:0] base;
    assign base = {mem_addr[11:2], 2'b00};

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++)
            if (mem_write && mem_write_to[i]) mem[base + 12'(i)] <= mem_write_value[8*i +: 8];
        rd1 <= {mem[base + 12'd3], mem[base + 12'd2], mem[base + 12'd1], mem[base]};
        rd2 <= rd1;
    end
    assign mem_read_value = rd2;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        mis;
        int          ecyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clock) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {27'd0, resp_rd}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("resp  cyc=%0d rd=%0d data=%h (expected rd=%0d data=%h cyc=%0d)",
                         cyc, resp_rd, resp_data, e.rd, e.data, e.ecyc);
                chk("resp_data", resp_data, e.data);
                chk("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
                chk("resp_cycle", cyc, e.ecyc);
`ifdef LSU_MISALIGN_TRAP_EN
                chk("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
`endif
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        ok = req_ready;
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] edata, input logic [31:0] eaddr,
                          input logic [3:0] ewt, input logic [31:0] ewv, input logic trap);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        drive(st, sz, un, a, wd, rd);
        e.data = edata;
        e.rd   = rd;
        e.mis  = trap;
        e.ecyc = cyc + (trap ? 1 : (st ? 2 : 4));
        sb.push_back(e);
        $display("req   cyc=%0d %s size=%0d uns=%0d addr=%h wdata=%h rd=%0d",
                 cyc, st ? "store" : "load ", sz, un, a, wd, rd);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("ready_low_A1", {31'd0, req_ready}, 32'd0);
        if (trap) begin
            chk("trap_no_write", {31'd0, mem_write}, 32'd0);
        end else begin
            chk("mem_write_A1", {31'd0, mem_write}, {31'd0, st});
            chk("mem_addr", mem_addr, eaddr);
            chk("mem_write_to", {28'd0, mem_write_to}, {28'd0, ewt});
            if (st) chk("mem_write_value", mem_write_value, ewv);
            @(posedge clock);
            #1;
            chk("mem_write_A2", {31'd0, mem_write}, 32'd0);
        end
    endtask

    initial begin
        bit ok;
        int n;
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0);
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_write_to", {28'd0, mem_write_to}, 32'd0);
        chk("rst_mem_write_value", mem_write_value, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);

        //     st    size   un   addr           wdata          rd     exp data                          mem_addr      wt       wv             trap
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 5'd1,  32'h0000_0000,                   32'h0000_0103, 4'b1000, 32'hA5A5_A5A5, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         5'd2,  32'hFFFF_FFA5,                   32'h0000_0103, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         5'd3,  32'h0000_00A5,                   32'h0000_0103, 4'b0000, 32'h0,         1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h0000_BEEF, 5'd4,  32'h0000_0000,                   32'h0000_0206, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0206, 32'h0,         5'd5,  32'hFFFF_BEEF,                   32'h0000_0206, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0206, 32'h0,         5'd6,  32'h0000_BEEF,                   32'h0000_0206, 4'b0000, 32'h0,         1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678, 5'd7,  32'h0000_0000,                   32'h0000_0040, 4'b1111, 32'h1234_5678, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         5'd8,  32'h1234_5678,                   32'h0000_0040, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0,         5'd9,  32'h0000_0056,                   32'h0000_0041, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0,         5'd10, 32'h0000_0012,                   32'h0000_0043, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0,         5'd11, 32'h0000_1234,                   32'h0000_0042, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         5'd12, 32'h1234_5678,                   32'h0000_0040, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_F040, 32'h0,         5'd13, 32'h1234_5678,                   32'h0000_0040, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'h0,         5'd14, TRAP ? 32'h0 : 32'h1234_5678,    32'h0000_0040, 4'b0000, 32'h0,         TRAP);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0207, 32'h0,         5'd15, TRAP ? 32'h0 : 32'hFFFF_BEEF,    32'h0000_0206, 4'b0000, 32'h0,         TRAP);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0045, 32'hDEAD_BEEF, 5'd16, 32'h0000_0000,                   32'h0000_0044, 4'b1111, 32'hDEAD_BEEF, TRAP);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0,         5'd17, TRAP ? 32'h0 : 32'hDEAD_BEEF,    32'h0000_0044, 4'b0000, 32'h0,         1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_0080, 5'd18, 32'h0000_0000,                   32'h0000_0301, 4'b0010, 32'h8080_8080, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0,         5'd19, 32'hFFFF_FF80,                   32'h0000_0301, 4'b0000, 32'h0,         1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0300, 32'h0,         5'd20, 32'h0000_8000,                   32'h0000_0300, 4'b0000, 32'h0,         1'b0);

        // Reset during WAIT1 of a load: no response may ever appear.
        wait_ready(ok);
        if (ok) begin
            drive(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd21);
            $display("req   cyc=%0d load  aborted by reset in WAIT1 rd=21", cyc);
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            @(posedge clock);
            #1;
            reset_n = 1'b0;
            @(posedge clock);
            #1;
            chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
            chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
            chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("abort_resp_data", resp_data, 32'd0);
            reset_n = 1'b1;
            repeat (6) @(posedge clock);
        end

        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd22, 32'h1234_5678, 32'h0000_0040, 4'b0000, 32'h0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) chk("drain_responses", sb.size(), 32'd0);
        repeat (2) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
